// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch stage: PC register, next-PC select, IF/ID
//            register. Define FETCH_STATS_EN to add redirect/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            JumpSelector,
    input  logic [31:0]     TargetAddress_Jump,
    input  logic            flush_JR,
    input  logic            BranchTaken,
    input  logic [31:0]     BranchTarget,
    input  logic [31:0]     ImemData,
    output logic [PC_W-1:0] ImemAddr,
    output logic [PC_W-1:0] PC,
    output logic [31:0]     IFID_Instr,
    output logic [PC_W-1:0] IFID_PCPlus1,
    output logic            IFID_Valid,
    output logic            FlushIDEX
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]     RedirectCount,
    output logic [15:0]     StallCount
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_plus1;
    logic [31:0]     r_ifid_instr;
    logic [PC_W-1:0] r_ifid_pcp1;
    logic            r_ifid_valid;
    logic            w_active;
    logic            w_ex_redirect;
    logic            w_id_take;
    logic            w_bubble;
    logic            w_capture;

    assign w_active      = (r_state != BOOT);
    assign w_ex_redirect = flush_JR | BranchTaken;
    // A J/JAL in ID is only honoured once the stall releases; it stays in ID
    assign w_id_take     = JumpSelector & ~flush_JR & ~Stall;
    assign w_pc_plus1    = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_bubble     = 1'b0;
        w_capture    = 1'b0;
        if (r_state == BOOT) begin
            w_state_next = RUN;
        end else begin
            if (flush_JR)
                w_pc_next = TargetAddress_Jump[PC_W-1:0];
            else if (BranchTaken)
                w_pc_next = BranchTarget[PC_W-1:0];
            else if (w_id_take)
                w_pc_next = TargetAddress_Jump[PC_W-1:0];
            else if (!Stall)
                w_pc_next = w_pc_plus1;

            w_bubble     = w_ex_redirect | w_id_take;
            w_capture    = ~w_ex_redirect & ~w_id_take & ~Stall;
            w_state_next = (w_ex_redirect || !Stall) ? RUN : HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_ifid_instr <= '0;
            r_ifid_pcp1  <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_bubble) begin
                r_ifid_instr <= '0;
                r_ifid_pcp1  <= '0;
                r_ifid_valid <= 1'b0;
            end else if (w_capture) begin
                r_ifid_instr <= ImemData;
                r_ifid_pcp1  <= w_pc_plus1;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    assign ImemAddr     = r_pc;
    assign PC           = r_pc;
    assign IFID_Instr   = r_ifid_instr;
    assign IFID_PCPlus1 = r_ifid_pcp1;
    assign IFID_Valid   = r_ifid_valid;
    assign FlushIDEX    = ~reset & w_active & w_ex_redirect;

`ifdef FETCH_STATS_EN
    logic [15:0] r_redirect_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_active && (w_ex_redirect || w_id_take) && r_redirect_cnt != 16'hFFFF)
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            if (r_state == HOLD && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign RedirectCount = r_redirect_cnt;
    assign StallCount    = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed scoreboard bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump_sel;
    logic [31:0] jump_tgt;
    logic        flush_jr;
    logic        br_taken;
    logic [31:0] br_tgt;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcp1;
    logic        ifid_valid;
    logic        flush_idex;
`ifdef FETCH_STATS_EN
    logic [15:0] redirect_count;
    logic [15:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp1;
        logic        valid;
    } exp_t;

    exp_t sb[$];

    fetch_stage #(
        .PC_W     (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .Stall              (stall),
        .JumpSelector       (jump_sel),
        .TargetAddress_Jump (jump_tgt),
        .flush_JR           (flush_jr),
        .BranchTaken        (br_taken),
        .BranchTarget       (br_tgt),
        .ImemData           (imem_data),
        .ImemAddr           (imem_addr),
        .PC                 (pc),
        .IFID_Instr         (ifid_instr),
        .IFID_PCPlus1       (ifid_pcp1),
        .IFID_Valid         (ifid_valid),
        .FlushIDEX          (flush_idex)
`ifdef FETCH_STATS_EN
        ,
        .RedirectCount      (redirect_count),
        .StallCount         (stall_count)
`endif
    );

    // Memory word k holds 0x1000_0000 + k
    assign imem_data = 32'h1000_0000 + imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check FlushIDEX before the edge, then compare
    // the post-edge PC and IF/ID against the queued expectation.
    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic js, input logic jr, input logic bt,
                        input logic [31:0] tj, input logic [31:0] btg,
                        input logic exp_flush, input logic [31:0] exp_pc,
                        input logic exp_valid, input logic [31:0] exp_instr,
                        input logic [31:0] exp_pcp1);
        exp_t e;
        reset    = rst;
        stall    = stl;
        jump_sel = js;
        flush_jr = jr;
        br_taken = bt;
        jump_tgt = tj;
        br_tgt   = btg;
        e.pc     = exp_pc;
        e.instr  = exp_instr;
        e.pcp1   = exp_pcp1;
        e.valid  = exp_valid;
        sb.push_back(e);
        #1;
        chk({tag, ".flush"}, {31'b0, flush_idex}, {31'b0, exp_flush});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"},    pc,         e.pc);
        chk({tag, ".instr"}, ifid_instr, e.instr);
        chk({tag, ".pcp1"},  ifid_pcp1,  e.pcp1);
        chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, e.valid});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; jump_sel = 1'b0; flush_jr = 1'b0;
        br_taken = 1'b0; jump_tgt = '0; br_tgt = '0;

        // Reset, with a redirect asserted that must be ignored
        step("rst0", 1, 0, 0, 1, 0, 32'h55, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        step("rst1", 1, 0, 0, 0, 0, 0, 0,      0, 32'h0, 0, 32'h0, 32'h0);

        // BOOT cycle, then sequential fetch
        step("boot",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0,         32'h0);
        step("seq0",  0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 1, 32'h1000_0000, 32'h1);
        step("seq1",  0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 1, 32'h1000_0001, 32'h2);
        step("seq2",  0, 0, 0, 0, 0, 0, 0, 0, 32'h3, 1, 32'h1000_0002, 32'h3);
        step("seq3",  0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h1000_0003, 32'h4);
        step("seq4",  0, 0, 0, 0, 0, 0, 0, 0, 32'h5, 1, 32'h1000_0004, 32'h5);

        // ID-class jump at PC=5
        step("jmp",   0, 0, 1, 0, 0, 32'h40, 0, 0, 32'h40, 0, 32'h0, 32'h0);
        step("jmp+1", 0, 0, 0, 0, 0, 0, 0,      0, 32'h41, 1, 32'h1000_0040, 32'h41);

        // JR overrides a stall
        step("jrst",  0, 1, 0, 1, 0, 32'h1F, 0, 1, 32'h1F, 0, 32'h0, 32'h0);
        step("jrst+1",0, 0, 0, 0, 0, 0, 0,      0, 32'h20, 1, 32'h1000_001F, 32'h20);

        // J in ID while stalled: held for two cycles, taken on release
        step("jstl0", 0, 1, 1, 0, 0, 32'h80, 0, 0, 32'h20, 1, 32'h1000_001F, 32'h20);
        step("jstl1", 0, 1, 1, 0, 0, 32'h80, 0, 0, 32'h20, 1, 32'h1000_001F, 32'h20);
        step("jrel",  0, 0, 1, 0, 0, 32'h80, 0, 0, 32'h80, 0, 32'h0, 32'h0);
        step("jrel+1",0, 0, 0, 0, 0, 0, 0,      0, 32'h81, 1, 32'h1000_0080, 32'h81);

        // JR and branch together: JR wins
        step("both",  0, 0, 0, 1, 1, 32'h10, 32'h20, 1, 32'h10, 0, 32'h0, 32'h0);
        step("both+1",0, 0, 0, 0, 0, 0, 0,            0, 32'h11, 1, 32'h1000_0010, 32'h11);

        // Branch alone
        step("br",    0, 0, 0, 0, 1, 0, 32'h30, 1, 32'h30, 0, 32'h0, 32'h0);
        step("br+1",  0, 0, 0, 0, 0, 0, 0,      0, 32'h31, 1, 32'h1000_0030, 32'h31);

        // PC wrap at all-ones
        step("brmax", 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0);
        step("wrap",  0, 0, 0, 0, 0, 0, 0,             0, 32'h0, 1, 32'h0FFF_FFFF, 32'h0);

        // Enter HOLD, then reset in the middle of it with a JR pending
        step("hold0", 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0FFF_FFFF, 32'h0);
        step("hold1", 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0FFF_FFFF, 32'h0);
        step("rsth",  1, 1, 0, 1, 0, 32'h77, 0, 0, 32'h0, 0, 32'h0, 32'h0);
`ifdef FETCH_STATS_EN
        chk("stat.rst.redir", {16'b0, redirect_count}, 32'd0);
        chk("stat.rst.stall", {16'b0, stall_count},    32'd0);
`endif

        // BOOT ignores stall and redirects
        step("boot2", 0, 1, 0, 1, 0, 32'h77, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        step("run2",  0, 0, 0, 0, 0, 0, 0,      0, 32'h1, 1, 32'h1000_0000, 32'h1);

        // Three stall cycles, then release
        step("st0",   0, 1, 0, 0, 0, 0, 0, 0, 32'h1, 1, 32'h1000_0000, 32'h1);
        step("st1",   0, 1, 0, 0, 0, 0, 0, 0, 32'h1, 1, 32'h1000_0000, 32'h1);
        step("st2",   0, 1, 0, 0, 0, 0, 0, 0, 32'h1, 1, 32'h1000_0000, 32'h1);
        step("strel", 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 1, 32'h1000_0001, 32'h2);
`ifdef FETCH_STATS_EN
        chk("stat.stall", {16'b0, stall_count}, 32'd3);
`endif

        // Two redirects
        step("rd0",   0, 0, 1, 0, 0, 32'h40, 0, 0, 32'h40, 0, 32'h0, 32'h0);
        step("rd1",   0, 0, 0, 0, 1, 0, 32'h50, 1, 32'h50, 0, 32'h0, 32'h0);
        step("rd1+1", 0, 0, 0, 0, 0, 0, 0,      0, 32'h51, 1, 32'h1000_0050, 32'h51);
`ifdef FETCH_STATS_EN
        chk("stat.redir", {16'b0, redirect_count}, 32'd2);
        chk("stat.stall2", {16'b0, stall_count},   32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
